skip_monitor: RTL and testbench

- Downstream consumer of the skip ring outputs: the skipped clock and the bit-0 marker.
- Both inputs are slow, free-running signals from the divided LED clock domain. They are re-sampled in the fast mCLK domain.
- Counts skipped-clock pulses per ring revolution and reports each revolution's count.
- Compares each count against an expected pulse count and raises sticky error / lock status for LEDs or a host.

---
 rtl/skip_monitor.sv | 195 +++++++++++++++++++
 tb/tb_skip_monitor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skip_monitor.sv
// Skip ring monitor: counts SCLK pulses per B0 revolution and tracks match/lock/error/stall status.
// Optional min/max count tracking is enabled by defining SKIP_MONITOR_MINMAX_EN.
module skip_monitor #(
    parameter int unsigned CW     = 8,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned TO_W   = 32
) (
    input  logic          mCLK,
    input  logic          nRST,
    input  logic          SCLK,
    input  logic          B0,
    input  logic [CW-1:0] EXPECT,
    input  logic          CLR,
    output logic [CW-1:0] COUNT,
    output logic          VALID,
    output logic          MATCH,
    output logic          LOCK,
    output logic          ERR,
    output logic          STALL
`ifdef SKIP_MONITOR_MINMAX_EN
    ,
    output logic [CW-1:0] CMIN,
    output logic [CW-1:0] CMAX
`endif
);

    localparam int unsigned MW = 8;
    localparam logic [MW-1:0]   LOCK_TGT = MW'(LOCK_N);
    localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
    localparam logic [TO_W-1:0] WD_MAX   = {TO_W{1'b1}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_dly_q, sclk_dly_d;
    logic            b0_meta_q, b0_meta_d, b0_sync_q, b0_sync_d, b0_dly_q, b0_dly_d;
    logic [CW-1:0]   pcnt_q, pcnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [MW-1:0]   mcnt_q, mcnt_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            valid_q, valid_d;
    logic            match_q, match_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic            stall_q, stall_d;

    logic            sclk_rise, b0_rise, rev_end, wd_trip, err_set;
    logic [MW-1:0]   mcnt_inc;

`ifdef SKIP_MONITOR_MINMAX_EN
    logic [CW-1:0]   cmin_q, cmin_d, cmax_q, cmax_d;
    logic [CW-1:0]   cmin_base, cmax_base;
`endif

    // Next-state, counters and status
    always_comb begin
        state_d     = state_q;
        sclk_meta_d = SCLK;
        sclk_sync_d = sclk_meta_q;
        sclk_dly_d  = sclk_sync_q;
        b0_meta_d   = B0;
        b0_sync_d   = b0_meta_q;
        b0_dly_d    = b0_sync_q;
        pcnt_d      = pcnt_q;
        count_d     = count_q;
        mcnt_d      = mcnt_q;
        wd_d        = wd_q;
        valid_d     = 1'b0;
        match_d     = match_q;
        lock_d      = lock_q;
        err_set     = 1'b0;

        sclk_rise = sclk_sync_q & ~sclk_dly_q;
        b0_rise   = b0_sync_q & ~b0_dly_q;
        rev_end   = (state_q == RUN) && b0_rise;
        wd_trip   = !b0_rise && (wd_q == (WD_MAX - TO_W'(1)));
        mcnt_inc  = (mcnt_q == LOCK_TGT) ? mcnt_q : (mcnt_q + MW'(1));

        if (b0_rise) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + TO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (b0_rise) begin
                    state_d = RUN;
                    pcnt_d  = sclk_rise ? CW'(1) : '0;
                end
            end
            RUN: begin
                if (b0_rise) begin
                    // A coincident SCLK edge opens the new revolution
                    count_d = pcnt_q;
                    valid_d = 1'b1;
                    pcnt_d  = sclk_rise ? CW'(1) : '0;
                    if (pcnt_q == EXPECT) begin
                        match_d = 1'b1;
                        mcnt_d  = mcnt_inc;
                        lock_d  = (mcnt_inc == LOCK_TGT);
                    end else begin
                        match_d = 1'b0;
                        mcnt_d  = '0;
                        lock_d  = 1'b0;
                        err_set = lock_q;
                    end
                end else if (sclk_rise && (pcnt_q != CNT_MAX)) begin
                    pcnt_d = pcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (wd_trip) begin
            state_d = IDLE;
            pcnt_d  = '0;
            mcnt_d  = '0;
            lock_d  = 1'b0;
        end

        err_d   = err_set | (err_q & ~CLR);
        stall_d = wd_trip | (stall_q & ~CLR);

`ifdef SKIP_MONITOR_MINMAX_EN
        cmin_base = CLR ? CNT_MAX : cmin_q;
        cmax_base = CLR ? '0 : cmax_q;
        cmin_d    = cmin_base;
        cmax_d    = cmax_base;
        if (rev_end && (pcnt_q < cmin_base)) cmin_d = pcnt_q;
        if (rev_end && (pcnt_q > cmax_base)) cmax_d = pcnt_q;
`endif
    end

    always_ff @(posedge mCLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_dly_q  <= 1'b0;
            b0_meta_q   <= 1'b0;
            b0_sync_q   <= 1'b0;
            b0_dly_q    <= 1'b0;
            pcnt_q      <= '0;
            count_q     <= '0;
            mcnt_q      <= '0;
            wd_q        <= '0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            b0_meta_q   <= b0_meta_d;
            b0_sync_q   <= b0_sync_d;
            b0_dly_q    <= b0_dly_d;
            pcnt_q      <= pcnt_d;
            count_q     <= count_d;
            mcnt_q      <= mcnt_d;
            wd_q        <= wd_d;
            valid_q     <= valid_d;
            match_q     <= match_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
        end
    end

`ifdef SKIP_MONITOR_MINMAX_EN
    always_ff @(posedge mCLK or negedge nRST) begin
        if (!nRST) begin
            cmin_q <= CNT_MAX;
            cmax_q <= '0;
        end else begin
            cmin_q <= cmin_d;
            cmax_q <= cmax_d;
        end
    end

    assign CMIN = cmin_q;
    assign CMAX = cmax_q;
`endif

    assign COUNT = count_q;
    assign VALID = valid_q;
    assign MATCH = match_q;
    assign LOCK  = lock_q;
    assign ERR   = err_q;
    assign STALL = stall_q;

endmodule

// File: tb/tb_skip_monitor.sv
// Randomized self-checking bench for skip_monitor (CW=3, LOCK_N=4, TO_W=8) against a per-revolution model.
module tb_skip_monitor;

    typedef struct packed {
        logic [2:0] count;
        logic       match;
        logic       lock;
        logic       err;
    } rec_t;

    logic       mclk = 1'b0;
    logic       nrst;
    logic       sclk;
    logic       b0;
    logic [2:0] expect_v;
    logic       clr;
    logic [2:0] count;
    logic       valid;
    logic       match;
    logic       lock;
    logic       err;
    logic       stall;

    int checks = 0;
    int errors = 0;

    // Model state: one revolution at a time
    rec_t       exp_q[$];
    rec_t       act_q[$];
    int         act_rd = 0;
    int         cur = 0;
    int         streak = 0;
    bit         armed = 0;
    bit         locked = 0;
    bit         err_m = 0;
    bit         stall_m = 0;
    logic [2:0] exp_m = 3'd0;

    localparam logic [15:0] RING_A = 16'h3445;  // 6 pulses, bit 0 set
    localparam logic [15:0] RING_B = 16'h3444;  // 5 pulses, bit 0 clear
    localparam logic [15:0] RING_S = 16'h03FF;  // 10 pulses

    always #5 mclk = ~mclk;

    skip_monitor #(.CW(3), .LOCK_N(4), .TO_W(8)) dut (
        .mCLK  (mclk),
        .nRST  (nrst),
        .SCLK  (sclk),
        .B0    (b0),
        .EXPECT(expect_v),
        .CLR   (clr),
        .COUNT (count),
        .VALID (valid),
        .MATCH (match),
        .LOCK  (lock),
        .ERR   (err),
        .STALL (stall)
    );

    always @(negedge mclk) begin
        if (valid === 1'b1) act_q.push_back(rec_t'({count, match, lock, err}));
    end

    task automatic model_reset();
        exp_q.delete();
        act_rd = act_q.size();
        cur = 0; streak = 0; armed = 0; locked = 0; err_m = 0; stall_m = 0;
    endtask

    // One revolution: slot 0 carries B0; EXPECT/CLR change at slot 8; VALID records checked at the end
    task automatic drive_rev(input logic [15:0] mask, input int nslots, input logic [2:0] new_exp,
                             input logic do_clr);
        int   cnt;
        bit   m;
        rec_t e, a;
        if (armed) begin
            cnt = (cur > 7) ? 7 : cur;
            m = (3'(cnt) == exp_m);
            if (m) begin
                streak = (streak < 4) ? streak + 1 : 4;
                locked = (streak == 4);
            end else begin
                if (locked) err_m = 1;
                streak = 0;
                locked = 0;
            end
            e.count = 3'(cnt); e.match = m; e.lock = locked; e.err = err_m;
            exp_q.push_back(e);
        end
        armed = 1;
        cur = $countones(mask);
        for (int i = 0; i < nslots; i++) begin
            @(negedge mclk);
            sclk = mask[i];
            b0 = (i == 0);
            if (i == 8) begin
                expect_v = new_exp;
                exp_m = new_exp;
                if (do_clr) begin
                    clr = 1'b1; err_m = 0; stall_m = 0;
                end
            end
            @(negedge mclk);
            clr = 1'b0;
            @(negedge mclk);
            sclk = 1'b0;
            b0 = 1'b0;
            @(negedge mclk);
        end
        while (act_rd < act_q.size() || exp_q.size() > 0) begin
            checks++;
            if (act_rd >= act_q.size()) begin
                e = exp_q.pop_front();
                errors++;
                $display("FAIL missing_valid expected cnt=%0d match=%0d lock=%0d err=%0d", e.count, e.match, e.lock, e.err);
            end else if (exp_q.size() == 0) begin
                a = act_q[act_rd];
                act_rd++;
                errors++;
                $display("FAIL extra_valid got cnt=%0d match=%0d lock=%0d err=%0d", a.count, a.match, a.lock, a.err);
            end else begin
                a = act_q[act_rd];
                act_rd++;
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL valid_rec got cnt=%0d match=%0d lock=%0d err=%0d want cnt=%0d match=%0d lock=%0d err=%0d",
                             a.count, a.match, a.lock, a.err, e.count, e.match, e.lock, e.err);
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; sclk = 1'b0; b0 = 1'b0; clr = 1'b0; expect_v = 3'd0;
        model_reset();
        #1;
        checks++;
        if ({count, valid, match, lock, err, stall} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000", {count, valid, match, lock, err, stall});
        end
        repeat (3) @(negedge mclk);
        nrst = 1'b1;
    endtask

    task automatic test_lock();
        int n0;
        n0 = act_q.size();
        for (int r = 0; r < 5; r++) drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (act_q.size() - n0 != 4) begin
            errors++;
            $display("FAIL lock_valid_count got %0d want 4", act_q.size() - n0);
        end
        checks++;
        if (lock !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL lock_status got lock=%b err=%b want lock=1 err=0", lock, err);
        end
    endtask

    task automatic test_error();
        drive_rev(RING_A, 16, 3'd5, 1'b0);
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (err !== 1'b1 || lock !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL err_set got err=%b lock=%b match=%b want 1 0 0", err, lock, match);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr got %b want 0", err);
        end
    endtask

    task automatic test_coincident();
        drive_rev(RING_B, 16, 3'd6, 1'b0);
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (count !== 3'd5) begin
            errors++;
            $display("FAIL coinc_first got %0d want 5", count);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (count !== 3'd6) begin
            errors++;
            $display("FAIL coinc_second got %0d want 6", count);
        end
    endtask

    task automatic test_saturate();
        drive_rev(RING_S, 16, 3'd7, 1'b0);
        drive_rev(RING_S, 16, 3'd6, 1'b0);
        checks++;
        if (count !== 3'd7 || match !== 1'b1) begin
            errors++;
            $display("FAIL sat_match got count=%0d match=%b want 7 1", count, match);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (count !== 3'd7 || match !== 1'b0) begin
            errors++;
            $display("FAIL sat_mismatch got count=%0d match=%b want 7 0", count, match);
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        logic [2:0]  ne;
        for (int r = 0; r < 24; r++) begin
            mask = 16'($urandom);
            ne = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : exp_m;
            if ($urandom_range(0, 3) != 0) mask = RING_A;
            drive_rev(mask, 16, ne, ($urandom_range(0, 5) == 0));
        end
        checks++;
        if (lock !== locked || err !== err_m) begin
            errors++;
            $display("FAIL rand_status got lock=%b err=%b want lock=%b err=%b", lock, err, locked, err_m);
        end
    endtask

    task automatic test_stall();
        for (int r = 0; r < 6; r++) drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL stall_prelock got %b want 1", lock);
        end
        repeat (187) @(negedge mclk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_early got %b want 0", stall);
        end
        repeat (12) @(negedge mclk);
        armed = 0; streak = 0; locked = 0; stall_m = 1;
        checks++;
        if (stall !== 1'b1 || lock !== 1'b0) begin
            errors++;
            $display("FAIL stall_trip got stall=%b lock=%b want 1 0", stall, lock);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (stall !== 1'b1 || count !== 3'd6) begin
            errors++;
            $display("FAIL stall_resume got stall=%b count=%0d want 1 6", stall, count);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b1);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_clr got %b want 0", stall);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        for (int r = 0; r < 6; r++) drive_rev(RING_A, 16, 3'd6, 1'b0);
        drive_rev(RING_A, 6, 3'd6, 1'b0);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_prelock got %b want 1", lock);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({count, valid, match, lock, err, stall} !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got %b want 00000000", {count, valid, match, lock, err, stall});
        end
        model_reset();
        repeat (3) @(negedge mclk);
        nrst = 1'b1;
        n0 = act_q.size();
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (act_q.size() != n0) begin
            errors++;
            $display("FAIL rstmid_first_b0 got %0d valids want 0", act_q.size() - n0);
        end
        drive_rev(RING_A, 16, 3'd6, 1'b0);
        checks++;
        if (act_q.size() - n0 != 1) begin
            errors++;
            $display("FAIL rstmid_second_b0 got %0d valids want 1", act_q.size() - n0);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_error();
        test_coincident();
        test_saturate();
        test_random();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
